// File: rtl/psum_accum_drain.sv
// Accumulates OFIFO psum vectors per output row over a run-time number of taps, then drains ReLU'd rows.
// Optional build macro PSUM_ACC_SAT_EN: saturating accumulate instead of two's-complement wrap.
module psum_accum_drain #(
  parameter int  col     = 8,
  parameter int  psum_bw = 16,
  parameter int  acc_bw  = 20,
  parameter int  depth   = 64,
  localparam int aw      = $clog2(depth)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [7:0]              cfg_ntaps,
  input  logic [aw:0]             cfg_nrows,
  input  logic [col*psum_bw-1:0]  ofifo_in,
  input  logic                    ofifo_valid,
  output logic                    ofifo_rd,
  output logic [col*acc_bw-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done
);

  localparam logic [aw:0] depth_v = (aw+1)'(depth);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, FIN} state_t;

  state_t                state;
  logic [7:0]            tap_cnt;
  logic [7:0]            tap_last;
  logic [aw-1:0]         row_cnt;
  logic [aw-1:0]         row_last;
  logic [aw:0]           nrows_clamped;
  logic [aw-1:0]         drain_idx;
  logic                  pop;
  logic                  last_row;
  logic                  last_tap;
  logic [col*acc_bw-1:0] acc_mem [depth];
  logic [col*acc_bw-1:0] acc_row;
  logic [col*acc_bw-1:0] acc_next;
  logic [col*acc_bw-1:0] drain_src;
  logic [col*acc_bw-1:0] drain_row;

  function automatic logic [acc_bw-1:0] acc_lane(input logic [acc_bw-1:0]  old,
                                                  input logic [psum_bw-1:0] x,
                                                  input logic               first);
    logic signed [acc_bw-1:0] ext;
`ifdef PSUM_ACC_SAT_EN
    logic signed [acc_bw:0]   wide;
    ext  = acc_bw'(signed'(x));
    wide = (acc_bw+1)'(signed'(old)) + (acc_bw+1)'(ext);
    if (first)
      return ext;
    // A sign mismatch between the guard bit and the MSB means the sum left the acc_bw range.
    if (wide[acc_bw] != wide[acc_bw-1])
      return wide[acc_bw] ? {1'b1, {(acc_bw-1){1'b0}}} : {1'b0, {(acc_bw-1){1'b1}}};
    return wide[acc_bw-1:0];
`else
    ext = acc_bw'(signed'(x));
    return first ? ext : old + ext;
`endif
  endfunction

  function automatic logic [acc_bw-1:0] relu(input logic [acc_bw-1:0] x);
    return x[acc_bw-1] ? '0 : x;
  endfunction

  assign nrows_clamped = (cfg_nrows > depth_v) ? depth_v : cfg_nrows;
  assign pop           = (state == ACCUM) && ofifo_valid;
  assign ofifo_rd      = pop;
  assign last_row      = (row_cnt == row_last);
  assign last_tap      = (tap_cnt == tap_last);
  assign acc_row       = acc_mem[row_cnt];
  // Once a row is on the output, the row to preload next is the following one.
  assign drain_idx     = out_valid ? row_cnt + aw'(1) : row_cnt;
  assign drain_src     = acc_mem[drain_idx];

  always_comb begin
    acc_next  = '0;
    drain_row = '0;
    for (int c = 0; c < col; c++) begin
      acc_next[c*acc_bw +: acc_bw]  = acc_lane(acc_row[c*acc_bw +: acc_bw],
                                               ofifo_in[c*psum_bw +: psum_bw],
                                               tap_cnt == 8'd0);
      drain_row[c*acc_bw +: acc_bw] = relu(drain_src[c*acc_bw +: acc_bw]);
    end
  end

  always_ff @(posedge clk) begin
    if (pop)
      acc_mem[row_cnt] <= acc_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tap_cnt   <= '0;
      row_cnt   <= '0;
      tap_last  <= '0;
      row_last  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tap_cnt  <= '0;
            row_cnt  <= '0;
            tap_last <= cfg_ntaps - 8'd1;
            // A clamp to a power-of-two depth leaves the low bits zero, so this still yields depth-1.
            row_last <= nrows_clamped[aw-1:0] - aw'(1);
            busy     <= 1'b1;
            if (cfg_ntaps == 8'd0 || nrows_clamped == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (ofifo_valid) begin
            if (last_row) begin
              row_cnt <= '0;
              if (last_tap)
                state <= DRAIN;
              else
                tap_cnt <= tap_cnt + 8'd1;
            end else begin
              row_cnt <= row_cnt + aw'(1);
            end
          end
        end
        DRAIN: begin
          if (!out_valid) begin
            out_data  <= drain_row;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            if (last_row) begin
              out_valid <= 1'b0;
              state     <= FIN;
              done      <= 1'b1;
            end else begin
              row_cnt   <= row_cnt + aw'(1);
              out_data  <= drain_row;
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
